// File: rtl/scan_pkg.sv
// Shared types and helpers for the one-hot digit scanner.
// State encoding, hex-to-7-segment table, phase rotation and one-hot check.
package scan_pkg;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCKING  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_e;

   // {g,f,e,d,c,b,a}, active-high, entries 0..F
   localparam logic [6:0] HEX7_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [3:0] rotl4(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

   function automatic logic onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment decoder.
// Output bit order {g,f,e,d,c,b,a}, active-high.
module seg7_hex_decode
   import scan_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = HEX7_TABLE[nib];

endmodule

// File: rtl/onehot_digit_scanner.sv
// Locks onto a left-rotating one-hot phase bus and scans a 4-digit display.
// Optional: define SCAN_ERRCNT_EN to implement the saturating err_count.
module onehot_digit_scanner
   import scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int LOCK_COUNT = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_DIGITS-1:0]     phase,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     blank_mask,
   output logic [6:0]                seg,
   output logic [NUM_DIGITS-1:0]     dig_en,
   output logic                      locked,
   output logic                      err,
   output logic [7:0]                err_count
);

   if ((NUM_DIGITS != 4) || (LOCK_COUNT < 1) || (LOCK_COUNT > 15)) begin : g_param_err
      $error("onehot_digit_scanner: unsupported NUM_DIGITS/LOCK_COUNT");
   end

   localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);

   state_e     state_q, state_d;
   logic [3:0] prev_phase_q;
   logic [3:0] adv_cnt_q, adv_cnt_d;
   logic [6:0] seg_q, seg_d;
   logic [3:0] dig_en_q, dig_en_d;
   logic       locked_q, locked_d;
   logic       err_q, err_d;
   logic       is_onehot, valid_step;
   logic [3:0] nib_sel;
   logic [6:0] seg_dec;

   assign is_onehot  = onehot4(phase);
   assign valid_step = is_onehot && (phase == rotl4(prev_phase_q));

   always_comb begin
      state_d   = state_q;
      adv_cnt_d = adv_cnt_q;
      err_d     = 1'b0;
      unique case (state_q)
         ST_UNLOCKED: begin
            if (is_onehot) begin
               state_d   = ST_LOCKING;
               adv_cnt_d = 4'd0;
            end
         end
         ST_LOCKING: begin
            if (valid_step) begin
               adv_cnt_d = adv_cnt_q + 4'd1;
               if (adv_cnt_d == LOCK_C) state_d = ST_LOCKED;
            end else if (is_onehot) begin
               adv_cnt_d = 4'd0;
            end else begin
               state_d = ST_UNLOCKED;
            end
         end
         ST_LOCKED: begin
            if (!valid_step) begin
               err_d     = 1'b1;
               adv_cnt_d = 4'd0;
               state_d   = is_onehot ? ST_LOCKING : ST_UNLOCKED;
            end
         end
         default: begin
            state_d   = ST_UNLOCKED;
            adv_cnt_d = 4'd0;
         end
      endcase
   end

   // Phase may be illegal outside LOCKED, so no unique qualifier here
   always_comb begin
      nib_sel = 4'd0;
      case (1'b1)
         phase[0]: nib_sel = digits[3:0];
         phase[1]: nib_sel = digits[7:4];
         phase[2]: nib_sel = digits[11:8];
         phase[3]: nib_sel = digits[15:12];
         default:  nib_sel = 4'd0;
      endcase
   end

   seg7_hex_decode u_dec (
      .nib (nib_sel),
      .seg (seg_dec)
   );

   always_comb begin
      locked_d = (state_d == ST_LOCKED);
      dig_en_d = 4'd0;
      seg_d    = 7'd0;
      if (locked_d) begin
         dig_en_d = phase & ~blank_mask;
         seg_d    = (dig_en_d != 4'd0) ? seg_dec : 7'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_UNLOCKED;
         prev_phase_q <= 4'd0;
         adv_cnt_q    <= 4'd0;
         seg_q        <= 7'd0;
         dig_en_q     <= 4'd0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_phase_q <= phase;
         adv_cnt_q    <= adv_cnt_d;
         seg_q        <= seg_d;
         dig_en_q     <= dig_en_d;
         locked_q     <= locked_d;
         err_q        <= err_d;
      end
   end

`ifdef SCAN_ERRCNT_EN
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_count_q <= 8'd0;
      else     err_count_q <= err_count_d;
   end

   assign err_count = err_count_q;
`else
   assign err_count = 8'h00;
`endif

   assign seg    = seg_q;
   assign dig_en = dig_en_q;
   assign locked = locked_q;
   assign err    = err_q;

endmodule

// File: tb/tb_onehot_digit_scanner.sv
// Directed self-checking bench for onehot_digit_scanner.
// Honours SCAN_ERRCNT_EN for the expected err_count values.
module tb_onehot_digit_scanner;

`ifdef SCAN_ERRCNT_EN
   localparam bit ERRCNT = 1'b1;
`else
   localparam bit ERRCNT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  phase;
   logic [15:0] digits;
   logic [3:0]  blank_mask;
   logic [6:0]  seg;
   logic [3:0]  dig_en;
   logic        locked;
   logic        err;
   logic [7:0]  err_count;

   int errors = 0;
   int checks = 0;

   onehot_digit_scanner #(.NUM_DIGITS(4), .LOCK_COUNT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .phase      (phase),
      .digits     (digits),
      .blank_mask (blank_mask),
      .seg        (seg),
      .dig_en     (dig_en),
      .locked     (locked),
      .err        (err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [3:0] p);
      phase = p;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic l, input logic [3:0] d,
                          input logic [6:0] s, input logic e);
      chk({tag, ".locked"}, {7'd0, locked}, {7'd0, l});
      chk({tag, ".dig_en"}, {4'd0, dig_en}, {4'd0, d});
      chk({tag, ".seg"}, {1'b0, seg}, {1'b0, s});
      chk({tag, ".err"}, {7'd0, err}, {7'd0, e});
   endtask

   initial begin
      int nerr;
      logic [7:0] max_cnt;
      rst = 1'b1;
      phase = 4'b0000;
      digits = 16'h4321;
      blank_mask = 4'b0000;
      step(4'b0000);
      step(4'b0000);
      rst = 1'b0;
      chk_out("reset", 1'b0, 4'b0000, 7'h00, 1'b0);
      chk("reset.cnt", err_count, 8'd0);

      // 1: lock on fifth phase sample
      step(4'b0001);
      chk_out("t1.p1", 1'b0, 4'b0000, 7'h00, 1'b0);
      step(4'b0010);
      step(4'b0100);
      step(4'b1000);
      chk_out("t1.p4", 1'b0, 4'b0000, 7'h00, 1'b0);
      step(4'b0001);
      chk_out("t1.lock", 1'b1, 4'b0001, 7'h06, 1'b0);
      step(4'b0010);
      chk_out("t1.d1", 1'b1, 4'b0010, 7'h5B, 1'b0);
      step(4'b0100);
      chk_out("t1.d2", 1'b1, 4'b0100, 7'h4F, 1'b0);
      step(4'b1000);
      chk_out("t1.d3", 1'b1, 4'b1000, 7'h66, 1'b0);

      // 2: non-one-hot glitch
      step(4'b0011);
      chk_out("t2.glitch", 1'b0, 4'b0000, 7'h00, 1'b1);
      chk("t2.cnt", err_count, ERRCNT ? 8'd1 : 8'd0);
      step(4'b0001);
      chk_out("t2.reacq", 1'b0, 4'b0000, 7'h00, 1'b0);
      step(4'b0010);
      step(4'b0100);
      step(4'b1000);
      chk_out("t2.adv3", 1'b0, 4'b0000, 7'h00, 1'b0);
      step(4'b0001);
      chk_out("t2.relock", 1'b1, 4'b0001, 7'h06, 1'b0);

      // 3: stall, then wrong order while LOCKING
      step(4'b0010);
      step(4'b0100);
      chk_out("t3.pre", 1'b1, 4'b0100, 7'h4F, 1'b0);
      step(4'b0100);
      chk_out("t3.stall", 1'b0, 4'b0000, 7'h00, 1'b1);
      chk("t3.cnt", err_count, ERRCNT ? 8'd2 : 8'd0);
      step(4'b1000);
      step(4'b0001);
      step(4'b0100);
      chk_out("t3.wrong1", 1'b0, 4'b0000, 7'h00, 1'b0);
      step(4'b0001);
      chk_out("t3.wrong2", 1'b0, 4'b0000, 7'h00, 1'b0);
      step(4'b0010);
      step(4'b0100);
      step(4'b1000);
      chk_out("t3.adv3", 1'b0, 4'b0000, 7'h00, 1'b0);
      step(4'b0001);
      chk_out("t3.relock", 1'b1, 4'b0001, 7'h06, 1'b0);

      // 4: other digits and blanking
      digits = 16'hF0A8;
      blank_mask = 4'b0010;
      step(4'b0010);
      chk_out("t4.blank", 1'b1, 4'b0000, 7'h00, 1'b0);
      step(4'b0100);
      chk_out("t4.d2", 1'b1, 4'b0100, 7'h3F, 1'b0);
      step(4'b1000);
      chk_out("t4.d3", 1'b1, 4'b1000, 7'h71, 1'b0);
      step(4'b0001);
      chk_out("t4.d0", 1'b1, 4'b0001, 7'h7F, 1'b0);

      // 5: reset while locked
      digits = 16'h4321;
      blank_mask = 4'b0000;
      rst = 1'b1;
      step(4'b0010);
      rst = 1'b0;
      chk_out("t5.rst", 1'b0, 4'b0000, 7'h00, 1'b0);
      chk("t5.cnt", err_count, 8'd0);
      step(4'b0001);
      step(4'b0010);
      step(4'b0100);
      step(4'b1000);
      chk_out("t5.adv3", 1'b0, 4'b0000, 7'h00, 1'b0);
      step(4'b0001);
      chk_out("t5.relock", 1'b1, 4'b0001, 7'h06, 1'b0);

      // 6: 300 violations, each followed by a full relock
      nerr = 0;
      max_cnt = 8'd0;
      for (int i = 0; i < 300; i++) begin
         step(4'b0000);
         if (err === 1'b1) nerr++;
         if (err_count > max_cnt) max_cnt = err_count;
         if (i == 9) chk("t6.cnt10", err_count, ERRCNT ? 8'd10 : 8'd0);
         if (i == 254) chk("t6.cnt255", err_count, ERRCNT ? 8'd255 : 8'd0);
         step(4'b0001);
         step(4'b0010);
         step(4'b0100);
         step(4'b1000);
         step(4'b0001);
      end
      chk("t6.pulses_lo", nerr[7:0], 8'(300 % 256));
      chk("t6.pulses_hi", nerr[15:8], 8'(300 / 256));
      chk("t6.relocked", {7'd0, locked}, 8'd1);
      chk("t6.final", err_count, ERRCNT ? 8'd255 : 8'd0);
      chk("t6.max", max_cnt, ERRCNT ? 8'd255 : 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
